// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One bit per cycle, LSB first, fixed latency of WIDTH cycles.
module twos_to_signmag #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             sign
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             r_sign_l;
  logic [WIDTH-1:0] r_out;
  logic             r_sign;

  logic             w_accept;
  logic             w_last;
  logic             w_obit;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_accept  = start && (r_state != SHIFT);
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
  // Negation: copy bits up to and including the first 1, invert the rest.
  assign w_obit    = r_sign_l ? (r_seen ? ~r_sreg[0] : r_sreg[0])
                              : r_sreg[0];
  assign w_res_nxt = {w_obit, r_res[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_sign_l <= 1'b0;
      r_out    <= '0;
      r_sign   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sreg   <= inA;
        r_sign_l <= inA[WIDTH-1];
        r_cnt    <= '0;
        r_seen   <= 1'b0;
        r_res    <= '0;
      end else if (r_state == SHIFT) begin
        r_sreg <= r_sreg >> 1;
        r_res  <= w_res_nxt;
        r_seen <= r_seen | r_sreg[0];
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_out  <= w_res_nxt;
        r_sign <= r_sign_l;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign out  = r_out;
  assign sign = r_sign;

endmodule

// File: doc/twos_to_signmag.md
Name: twos_to_signmag

Overview:
- Bit-serial converter from 16-bit two's-complement to sign-magnitude form.
- It is the reverse direction of the datapath's invert/negate path, which produces one's/two's complement operands for subtraction.
- Used by the multi-cycle multiply/divide path and the debug/trace port, which need an unsigned magnitude plus a separate sign.
- Start/busy/done handshake with fixed latency; one bit processed per cycle, LSB first.

Parameters:
- WIDTH, 16, operand width in bits (>= 2).
- CNT_W, 4, counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of inA; sampled on the rising edge.
- inA  input  WIDTH  two's-complement operand; sampled only on an accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; out and sign are valid from this cycle on.
- out  output  WIDTH  magnitude |inA|, unsigned.
- sign  output  1  sign of the converted operand (inA[WIDTH-1]).

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy=0, done=0, out=0, sign=0.
  - Shift register, result register, counter and seen_one all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge accepts the operand: sreg<=inA, sign_l<=inA[WIDTH-1], cnt<=0, seen_one<=0, res<=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), one bit per edge:
  - b=sreg[0].
  - obit = sign_l ? (seen_one ? ~b : b) : b. This is the copy-through-first-1-then-invert negation rule.
  - res<={obit, res[WIDTH-1:1]}; sreg<=sreg>>1; seen_one<=seen_one|b; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: out<={obit, res[WIDTH-1:1]}, sign<=sign_l, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back conversion, no bubble); otherwise go to IDLE.
- Latency:
  - start sampled at edge E0; shifts occur at edges E1..E_WIDTH; done is high in the cycle after edge E_WIDTH.
  - Start to done is WIDTH cycles (16 at default), constant for every operand including positive ones.
- out and sign:
  - Change only at the edge entering DONE; partial results never appear on the ports.
  - Hold their values until the next conversion completes or reset.
- start while in SHIFT: ignored; no effect on the in-flight conversion or on inA capture.
- inA may change freely after the accepting edge.
- Arithmetic:
  - The magnitude is WIDTH bits wide, so the most-negative input 2^(WIDTH-1) yields out=2^(WIDTH-1), sign=1, with no overflow.
  - Zero yields out=0, sign=0.
- Reset asserted mid-conversion:
  - Immediate abort to IDLE with all outputs cleared.
  - No done pulse.
  - A start on the first edge after reset release is accepted normally.
- busy and done are never high simultaneously.

Test Plan:
- Reset; start with inA=0xFFFF -> busy high 16 cycles; done pulse 16 cycles after the start edge; out=0x0001, sign=1.
- inA=0x8000 -> out=0x8000, sign=1. inA=0x0000 -> out=0x0000, sign=0. Both take the same 16-cycle latency.
- inA=0x1234 -> out=0x1234, sign=0. inA=0xFF9C (-100) -> out=0x0064, sign=1. out must hold its previous value until done.
- Start 0xFFF6 (-10), then pulse start with 0x0005 at cycle 5 of SHIFT -> the second start is ignored; out=0x000A, sign=1; done pulses once.
- Back-to-back: start 0xFFFE accepted; assert start with 0x7FFF during the done cycle -> first done gives out=0x0002, sign=1; second done exactly 16 cycles later gives out=0x7FFF, sign=0.
- Assert rst at cycle 8 of a conversion of 0xC000 -> outputs immediately 0, no done pulse; after release, a new start with 0xC000 -> out=0x4000, sign=1.
